alu_seq_unit: RTL and testbench

//  Parametrised, clocked successor to the combinational datapath ALU. It accepts one

---
 rtl/alu_seq_unit.sv | 177 +++++++++++++++++
 tb/tb_alu_seq_unit.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// Sequential ALU: one operation per valid/ready handshake, registered result and flags.
// LSL/LSR either complete in one cycle or shift one bit per cycle when SHIFT_ITER=1.
module alu_seq_unit #(
    parameter int W          = 8,
    parameter int SHIFT_ITER = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         In_valid,
    output logic         In_ready,
    input  logic [2:0]   Op,
    input  logic [W-1:0] Arg_0,
    input  logic [W-1:0] Arg_1,
    input  logic         Carry_in,
    output logic         Out_valid,
    input  logic         Out_ready,
    output logic [W-1:0] Result,
    output logic         Carry_out,
    output logic         Zero,
    output logic         Beven,
    output logic         Parity,
    output logic         Equal,
    output logic         Busy
);

    localparam int            CW      = $clog2(W + 1);
    localparam logic [W-1:0]  W_VAL   = W[W-1:0];
    localparam logic [CW-1:0] CNT_MAX = W[CW-1:0];
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [W:0]    SUM_ONE = {{W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    typedef enum logic [2:0] {
        OP_ADD = 3'd0, OP_LSL = 3'd1, OP_XOR = 3'd2, OP_AND = 3'd3,
        OP_CMP = 3'd4, OP_SET = 3'd5, OP_LSR = 3'd6, OP_SUB = 3'd7
    } op_t;

    state_t        r_state, w_state_nxt;
    op_t           w_op;
    logic          w_accept, w_is_shift, w_iter;
    logic [CW-1:0] w_cnt;
    logic [W:0]    w_sum, w_lsl_ext, w_lsr_ext;
    logic [W-1:0]  w_res;
    logic          w_cout;
    logic [W:0]    w_first_step, w_acc_step;

    logic [W-1:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_is_lsl, r_par_cap, r_eq_cap;
    logic [W-1:0]  r_result;
    logic          r_cout, r_zero, r_beven, r_parity, r_equal;

    // Single-bit shift step; returns {bit shifted out, shifted value}.
    function automatic logic [W:0] f_step(input logic [W-1:0] v, input logic lsl);
        if (lsl)
            return {v[W-1], v[W-2:0], 1'b0};
        return {v[0], 1'b0, v[W-1:1]};
    endfunction

    assign w_op         = op_t'(Op);
    assign w_accept     = In_valid & In_ready;
    assign w_cnt        = (Arg_1 > W_VAL) ? CNT_MAX : Arg_1[CW-1:0];
    assign w_is_shift   = (w_op == OP_LSL) || (w_op == OP_LSR);
    assign w_iter       = (SHIFT_ITER != 0) && w_is_shift && (w_cnt > CNT_ONE);
    assign w_lsl_ext    = {1'b0, Arg_0} << w_cnt;
    assign w_lsr_ext    = {Arg_0, 1'b0} >> w_cnt;
    assign w_first_step = f_step(Arg_0, w_op == OP_LSL);
    assign w_acc_step   = f_step(r_acc, r_is_lsl);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        w_sum  = '0;
        w_res  = '0;
        w_cout = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_sum  = {1'b0, Arg_0} + {1'b0, Arg_1} + {{W{1'b0}}, Carry_in};
                w_res  = w_sum[W-1:0];
                w_cout = w_sum[W];
            end
            OP_SUB, OP_CMP: begin
                w_sum  = {1'b0, Arg_0} + {1'b0, ~Arg_1} + SUM_ONE;
                w_res  = (w_op == OP_SUB) ? w_sum[W-1:0] : '0;
                w_cout = w_sum[W];
            end
            OP_XOR: w_res = Arg_0 ^ Arg_1;
            OP_AND: w_res = Arg_0 & Arg_1;
            OP_SET: w_res = Arg_1;
            OP_LSL: begin
                w_res  = w_lsl_ext[W-1:0];
                w_cout = w_lsl_ext[W];
            end
            OP_LSR: begin
                w_res  = w_lsr_ext[W:1];
                w_cout = w_lsr_ext[0];
            end
            default: w_res = '0;
        endcase
    end

    // NOTE: all clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_iter ? S_SHIFT : S_DONE;
            S_SHIFT: if (r_cnt == CNT_ONE) w_state_nxt = S_DONE;
            S_DONE: begin
                if (w_accept)
                    w_state_nxt = w_iter ? S_SHIFT : S_DONE;
                else if (Out_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Accept already performs the first shift step, so SHIFT lasts count-1 cycles.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_is_lsl  <= 1'b0;
            r_par_cap <= 1'b0;
            r_eq_cap  <= 1'b0;
            r_result  <= '0;
            r_cout    <= 1'b0;
            r_zero    <= 1'b0;
            r_beven   <= 1'b0;
            r_parity  <= 1'b0;
            r_equal   <= 1'b0;
        end else if (w_accept) begin
            r_par_cap <= ^Arg_0;
            r_eq_cap  <= (Arg_0 == Arg_1);
            r_is_lsl  <= (w_op == OP_LSL);
            if (w_iter) begin
                r_acc <= w_first_step[W-1:0];
                r_cnt <= w_cnt - CNT_ONE;
            end else begin
                r_result <= w_res;
                r_cout   <= w_cout;
                r_zero   <= (w_res == '0);
                r_beven  <= ~w_res[0];
                r_parity <= ^Arg_0;
                r_equal  <= (Arg_0 == Arg_1);
            end
        end else if (r_state == S_SHIFT) begin
            r_acc <= w_acc_step[W-1:0];
            r_cnt <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
                r_result <= w_acc_step[W-1:0];
                r_cout   <= w_acc_step[W];
                r_zero   <= (w_acc_step[W-1:0] == '0);
                r_beven  <= ~w_acc_step[0];
                r_parity <= r_par_cap;
                r_equal  <= r_eq_cap;
            end
        end
    end

    assign In_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && Out_ready);
    assign Out_valid = (r_state == S_DONE);
    assign Busy      = (r_state == S_SHIFT);
    assign Result    = r_result;
    assign Carry_out = r_cout;
    assign Zero      = r_zero;
    assign Beven     = r_beven;
    assign Parity    = r_parity;
    assign Equal     = r_equal;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: one iterative-shift and one single-cycle-shift
// instance share stimulus; sel routes In_valid and observation to one of them.
module tb_alu_seq_unit;

    typedef struct packed {
        logic [7:0] res;
        logic       cout;
        logic       zero;
        logic       beven;
        logic       par;
        logic       eq;
    } flags_t;

    typedef struct {
        flags_t f;
        int     lat;
        int     busy;
    } exp_t;

    typedef struct {
        bit         sel;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        flags_t     f;
        int         lat;
        int         busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [2:0] op = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    bit         sel = 1'b1;

    logic       iv1, ir1, ov1, co1, z1, be1, p1, e1, bsy1;
    logic       iv0, ir0, ov0, co0, z0, be0, p0, e0, bsy0;
    logic [7:0] res1, res0;
    logic       o_in_ready, o_out_valid, o_busy;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    assign iv1 = in_valid & sel;
    assign iv0 = in_valid & ~sel;
    assign o_in_ready  = sel ? ir1 : ir0;
    assign o_out_valid = sel ? ov1 : ov0;
    assign o_busy      = sel ? bsy1 : bsy0;

    always #5 clk = ~clk;

    alu_seq_unit #(.W(8), .SHIFT_ITER(1)) dut_iter (
        .Clk(clk), .Reset(rst_n), .In_valid(iv1), .In_ready(ir1), .Op(op),
        .Arg_0(a), .Arg_1(b), .Carry_in(cin), .Out_valid(ov1), .Out_ready(out_ready),
        .Result(res1), .Carry_out(co1), .Zero(z1), .Beven(be1), .Parity(p1),
        .Equal(e1), .Busy(bsy1)
    );

    alu_seq_unit #(.W(8), .SHIFT_ITER(0)) dut_flat (
        .Clk(clk), .Reset(rst_n), .In_valid(iv0), .In_ready(ir0), .Op(op),
        .Arg_0(a), .Arg_1(b), .Carry_in(cin), .Out_valid(ov0), .Out_ready(out_ready),
        .Result(res0), .Carry_out(co0), .Zero(z0), .Beven(be0), .Parity(p0),
        .Equal(e0), .Busy(bsy0)
    );

    function automatic flags_t outs();
        return sel ? {res1, co1, z1, be1, p1, e1} : {res0, co0, z0, be0, p0, e0};
    endfunction

    function automatic flags_t mk(input logic [7:0] r, input logic c, z, be, p, e);
        return {r, c, z, be, p, e};
    endfunction

    function automatic exp_t ex(input flags_t f, input int lat, input int busy);
        exp_t e;
        e.f = f;
        e.lat = lat;
        e.busy = busy;
        return e;
    endfunction

    // Reference model written from the operation definitions, shifts done bit by bit.
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, y,
                                   input logic c, input bit iter);
        exp_t       e;
        logic [8:0] s;
        logic [7:0] v;
        logic       co;
        int         n;
        v  = x;
        co = 1'b0;
        n  = (y > 8'd8) ? 8 : int'(y);
        case (o)
            3'd0: begin s = {1'b0, x} + {1'b0, y} + {8'd0, c}; v = s[7:0]; co = s[8]; end
            3'd7: begin v = x - y; co = (x >= y); end
            3'd4: begin v = 8'h00; co = (x >= y); end
            3'd2: v = x ^ y;
            3'd3: v = x & y;
            3'd5: v = y;
            3'd1: for (int i = 0; i < n; i++) begin co = v[7]; v = {v[6:0], 1'b0}; end
            default: for (int i = 0; i < n; i++) begin co = v[0]; v = {1'b0, v[7:1]}; end
        endcase
        e.f = {v, co, (v == 8'h00), ~v[0], ^x, (x == y)};
        if (iter && (o == 3'd1 || o == 3'd6) && n > 1) begin
            e.lat = n;
            e.busy = n - 1;
        end else begin
            e.lat = 1;
            e.busy = 0;
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [2:0] o, input logic [7:0] x, y, input logic c,
                         input exp_t e);
        int n;
        n = 0;
        op = o; a = x; b = y; cin = c; in_valid = 1'b1;
        #1;
        while (!o_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready=%b required 1", o_in_ready);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic await_out(output int lat, output int busy);
        lat = 1;
        busy = 0;
        while (!o_out_valid && lat < 40) begin
            busy += int'(o_busy);
            @(negedge clk);
            lat++;
        end
        if (!o_out_valid) begin
            total++; bad++;
            $display("FAIL out_valid_timeout: out_valid=%b required 1", o_out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({res1, co1, z1, be1, p1, e1, ov1, bsy1} !== 14'h0) begin
            bad++;
            $display("FAIL reset_iter: got %h required 0", {res1, co1, z1, be1, p1, e1, ov1, bsy1});
        end
        total++;
        if ({res0, co0, z0, be0, p0, e0, ov0, bsy0} !== 14'h0) begin
            bad++;
            $display("FAIL reset_flat: got %h required 0", {res0, co0, z0, be0, p0, e0, ov0, bsy0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({ir1, ir0, ov1, ov0} !== 4'b1100) begin
            bad++;
            $display("FAIL reset_ready: got %b required 1100", {ir1, ir0, ov1, ov0});
        end
    endtask

    task automatic test_arith();
        vec_t v[$];
        exp_t e;
        int   lat, busy;
        v.push_back('{1'b1, 3'd0, 8'hFF, 8'h01, 1'b0, mk(8'h00, 1, 1, 1, 0, 0), 1, 0});
        v.push_back('{1'b1, 3'd7, 8'h05, 8'h07, 1'b0, mk(8'hFE, 0, 0, 1, 0, 0), 1, 0});
        v.push_back('{1'b1, 3'd4, 8'h07, 8'h07, 1'b0, mk(8'h00, 1, 1, 1, 1, 1), 1, 0});
        v.push_back('{1'b0, 3'd0, 8'h7F, 8'h80, 1'b1, mk(8'h00, 1, 1, 1, 1, 0), 1, 0});
        v.push_back('{1'b0, 3'd3, 8'hF0, 8'h0F, 1'b0, mk(8'h00, 0, 1, 1, 0, 0), 1, 0});
        v.push_back('{1'b0, 3'd5, 8'h12, 8'h34, 1'b0, mk(8'h34, 0, 0, 1, 0, 0), 1, 0});
        v.push_back('{1'b1, 3'd7, 8'h80, 8'h01, 1'b0, mk(8'h7F, 1, 0, 0, 1, 0), 1, 0});
        foreach (v[i]) begin
            sel = v[i].sel;
            issue(v[i].op, v[i].a, v[i].b, v[i].c, ex(v[i].f, v[i].lat, v[i].busy));
            await_out(lat, busy);
            if (sb.size() == 0) continue;
            e = sb.pop_front();
            total++;
            if (outs() !== e.f) begin
                bad++;
                $display("FAIL arith[%0d] flags: got %h required %h", i, outs(), e.f);
            end
            total++;
            if (lat !== e.lat) begin
                bad++;
                $display("FAIL arith[%0d] latency: got %0d required %0d", i, lat, e.lat);
            end
        end
    endtask

    task automatic test_shift();
        vec_t v[$];
        exp_t e;
        int   lat, busy;
        v.push_back('{1'b1, 3'd1, 8'hB3, 8'd3, 1'b0, mk(8'h98, 1, 0, 1, 1, 0), 3, 2});
        v.push_back('{1'b1, 3'd6, 8'hB3, 8'd9, 1'b0, mk(8'h00, 1, 1, 1, 1, 0), 8, 7});
        v.push_back('{1'b1, 3'd6, 8'hB3, 8'd3, 1'b0, mk(8'h16, 0, 0, 1, 1, 0), 3, 2});
        v.push_back('{1'b1, 3'd1, 8'hB3, 8'd1, 1'b0, mk(8'h66, 1, 0, 1, 1, 0), 1, 0});
        v.push_back('{1'b0, 3'd1, 8'hB3, 8'd3, 1'b0, mk(8'h98, 1, 0, 1, 1, 0), 1, 0});
        v.push_back('{1'b0, 3'd6, 8'hB3, 8'd9, 1'b0, mk(8'h00, 1, 1, 1, 1, 0), 1, 0});
        v.push_back('{1'b0, 3'd6, 8'hB3, 8'd3, 1'b0, mk(8'h16, 0, 0, 1, 1, 0), 1, 0});
        foreach (v[i]) begin
            sel = v[i].sel;
            issue(v[i].op, v[i].a, v[i].b, v[i].c, ex(v[i].f, v[i].lat, v[i].busy));
            await_out(lat, busy);
            if (sb.size() == 0) continue;
            e = sb.pop_front();
            total++;
            if (outs() !== e.f) begin
                bad++;
                $display("FAIL shift[%0d] flags: got %h required %h", i, outs(), e.f);
            end
            total++;
            if (lat !== e.lat || busy !== e.busy) begin
                bad++;
                $display("FAIL shift[%0d] timing: lat=%0d busy=%0d required lat=%0d busy=%0d",
                         i, lat, busy, e.lat, e.busy);
            end
        end
    endtask

    task automatic test_hold_back_to_back();
        exp_t e;
        int   lat, busy;
        sel = 1'b1;
        out_ready = 1'b0;
        issue(3'd7, 8'h05, 8'h07, 1'b0, ex(mk(8'hFE, 0, 0, 1, 0, 0), 1, 0));
        await_out(lat, busy);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                total++;
                if ({o_out_valid, o_in_ready, outs()} !== {1'b1, 1'b0, e.f}) begin
                    bad++;
                    $display("FAIL hold[%0d]: got %h required %h", k,
                             {o_out_valid, o_in_ready, outs()}, {1'b1, 1'b0, e.f});
                end
            end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (o_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready: in_ready=%b required 1", o_in_ready);
        end
        issue(3'd2, 8'h0F, 8'hFF, 1'b0, ex(mk(8'hF0, 0, 0, 1, 0, 0), 1, 0));
        await_out(lat, busy);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            total++;
            if (outs() !== e.f || lat !== e.lat) begin
                bad++;
                $display("FAIL b2b_xor: got %h lat=%0d required %h lat=%0d", outs(), lat, e.f, e.lat);
            end
        end
    endtask

    task automatic test_reset_midop();
        int seen;
        sel = 1'b1;
        out_ready = 1'b1;
        issue(3'd6, 8'hB3, 8'd8, 1'b0, model(3'd6, 8'hB3, 8'd8, 1'b0, 1'b1));
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({o_out_valid, outs().res, o_in_ready, o_busy} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_midop: ov=%b res=%h ir=%b busy=%b required 0 00 1 0",
                     o_out_valid, outs().res, o_in_ready, o_busy);
        end
        sb.delete();
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            seen += int'(o_out_valid);
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_aborted_op: out_valid cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_shift_zero();
        exp_t e;
        int   lat, busy;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 0);
            issue(3'd1, 8'h5A, 8'd0, 1'b0, ex(mk(8'h5A, 0, 0, 1, 0, 0), 1, 0));
            await_out(lat, busy);
            if (sb.size() == 0) continue;
            e = sb.pop_front();
            total++;
            if (outs() !== e.f || lat !== e.lat || busy !== e.busy) begin
                bad++;
                $display("FAIL shift_zero[%0d]: got %h lat=%0d busy=%0d required %h lat=1 busy=0",
                         s, outs(), lat, busy, e.f);
            end
        end
    endtask

    task automatic test_random();
        exp_t       e;
        int         lat, busy;
        logic [2:0] o;
        logic [7:0] x, y;
        logic       c;
        for (int i = 0; i < 60; i++) begin
            sel = 1'($urandom_range(0, 1));
            o = 3'($urandom_range(0, 7));
            x = 8'($urandom);
            y = (o == 3'd1 || o == 3'd6) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            if (i % 7 == 0) y = x;
            c = 1'($urandom_range(0, 1));
            issue(o, x, y, c, model(o, x, y, c, sel));
            await_out(lat, busy);
            if (sb.size() == 0) continue;
            e = sb.pop_front();
            total++;
            if (outs() !== e.f || lat !== e.lat || busy !== e.busy) begin
                bad++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat=%0d busy=%0d required %h lat=%0d busy=%0d",
                         i, o, x, y, outs(), lat, busy, e.f, e.lat, e.busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift();
        test_hold_back_to_back();
        test_reset_midop();
        test_shift_zero();
        test_random();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
